// File: rtl/ball_motion.sv
// ball_motion: moves the game ball through a ballistic flight, one step per
// video frame, holds it after landing and then returns it to the start spot.
// Optional feature macro: BALL_BOUNCE_EN (floor hits rebound with half speed
// until the downward speed drops below 2 px/frame).
module ball_motion #(
    parameter int START_X     = 100,
    parameter int START_Y     = 400,
    parameter int BALL_SIZE   = 16,
    parameter int FLOOR_Y     = 464,
    parameter int RIGHT_X     = 624,
    parameter int HOLD_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       launch,
    input  logic [3:0] launch_vx,
    input  logic [4:0] launch_vy,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       in_flight,
    output logic       shot_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLIGHT = 2'd1,
        ST_LANDED = 2'd2
    } state_t;

    localparam int CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [9:0] X_START = 10'(START_X);
    localparam logic [9:0] Y_START = 10'(START_Y);
    localparam logic signed [10:0] X_LIM = 11'(RIGHT_X - BALL_SIZE);
    localparam logic signed [10:0] Y_LIM = 11'(FLOOR_Y - BALL_SIZE);

    state_t                state_r, state_next_s;
    logic [9:0]            x_r, x_next_s;
    logic [9:0]            y_r, y_next_s;
    logic [3:0]            vx_r, vx_next_s;
    logic signed [7:0]     vy_r, vy_next_s;
    logic [CNT_W-1:0]      cnt_r, cnt_next_s;
    logic                  in_flight_r, in_flight_next_s;
    logic                  shot_r, shot_next_s;
    logic                  landed_s;
    logic signed [10:0]    sum_x_s;
    logic signed [10:0]    sum_y_s;
    logic signed [7:0]     vy_inc_s;

    // Candidate positions and gravity-updated speed for the current frame.
    always_comb begin
        sum_x_s = $signed({1'b0, x_r}) + $signed({7'b0000000, vx_r});
        sum_y_s = $signed({1'b0, y_r}) + $signed({{3{vy_r[7]}}, vy_r});
        if (vy_r >= 8'sd31) begin
            vy_inc_s = 8'sd31;
        end else begin
            vy_inc_s = vy_r + 8'sd1;
        end
    end

    // Next-state and datapath decisions for the three-state motion FSM.
    always_comb begin
        state_next_s = state_r;
        x_next_s     = x_r;
        y_next_s     = y_r;
        vx_next_s    = vx_r;
        vy_next_s    = vy_r;
        cnt_next_s   = cnt_r;
        shot_next_s  = 1'b0;
        landed_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                x_next_s   = X_START;
                y_next_s   = Y_START;
                cnt_next_s = '0;
                // A launch wins over a coincident frame tick: no motion this frame.
                if (launch) begin
                    vx_next_s    = launch_vx;
                    vy_next_s    = -$signed({3'b000, launch_vy});
                    state_next_s = ST_FLIGHT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FLIGHT: begin
                if (frame_tick) begin
                    vy_next_s = vy_inc_s;
                    if (sum_x_s >= X_LIM) begin
                        x_next_s = X_LIM[9:0];
                        landed_s = 1'b1;
                    end else begin
                        x_next_s = sum_x_s[9:0];
                    end
                    if (sum_y_s < 11'sd0) begin
                        y_next_s  = 10'd0;
                        vy_next_s = 8'sd0;
                    end else if (sum_y_s >= Y_LIM) begin
                        y_next_s = Y_LIM[9:0];
`ifdef BALL_BOUNCE_EN
                        // Rebound at half speed; a slow ball just settles.
                        if (vy_r < 8'sd2) begin
                            landed_s = 1'b1;
                        end else begin
                            vy_next_s = -(vy_r >>> 1);
                        end
`else
                        landed_s = 1'b1;
`endif
                    end else begin
                        y_next_s = sum_y_s[9:0];
                    end
                    if (landed_s) begin
                        state_next_s = ST_LANDED;
                        shot_next_s  = 1'b1;
                        cnt_next_s   = '0;
                    end else begin
                        state_next_s = ST_FLIGHT;
                    end
                end else begin
                    state_next_s = ST_FLIGHT;
                end
            end
            ST_LANDED: begin
                if (frame_tick) begin
                    if (cnt_r == HOLD_LAST) begin
                        state_next_s = ST_IDLE;
                        cnt_next_s   = '0;
                        x_next_s     = X_START;
                        y_next_s     = Y_START;
                    end else begin
                        cnt_next_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_next_s = ST_LANDED;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                x_next_s     = X_START;
                y_next_s     = Y_START;
                cnt_next_s   = '0;
            end
        endcase
        in_flight_next_s = (state_next_s == ST_FLIGHT);
    end

    // State and datapath registers; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            x_r         <= X_START;
            y_r         <= Y_START;
            vx_r        <= 4'd0;
            vy_r        <= 8'sd0;
            cnt_r       <= '0;
            in_flight_r <= 1'b0;
            shot_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            x_r         <= x_next_s;
            y_r         <= y_next_s;
            vx_r        <= vx_next_s;
            vy_r        <= vy_next_s;
            cnt_r       <= cnt_next_s;
            in_flight_r <= in_flight_next_s;
            shot_r      <= shot_next_s;
        end
    end

    assign ball_x    = x_r;
    assign ball_y    = y_r;
    assign in_flight = in_flight_r;
    assign shot_done = shot_r;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: a frame-level reference model pushes the
// expected outputs for every cycle into a scoreboard queue, which is popped
// and compared after each clock edge; key positions are also checked directly.
module tb_ball_motion;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       launch = 1'b0;
    logic [3:0] launch_vx = 4'd0;
    logic [4:0] launch_vy = 5'd0;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       in_flight;
    logic       shot_done;

    int n_assert = 0;
    int n_fail   = 0;
    int shots    = 0;
    string phase = "init";
    logic [21:0] sb_q[$];

    // reference model state
    int mstate = 0;
    int mx = 100, my = 400, mvx = 0, mvy = 0, mcnt = 0;
    bit msd = 1'b0;

    ball_motion dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .launch(launch),
        .launch_vx(launch_vx), .launch_vy(launch_vy),
        .ball_x(ball_x), .ball_y(ball_y), .in_flight(in_flight), .shot_done(shot_done)
    );

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    task automatic model_step(input bit l, input bit t, input bit r);
        int nx, ny, nvy;
        bit land;
        msd = 1'b0;
        if (r) begin
            mstate = 0; mx = 100; my = 400; mvx = 0; mvy = 0; mcnt = 0;
        end else if (mstate == 0) begin
            mx = 100; my = 400; mcnt = 0;
            if (l) begin
                mvx = int'(launch_vx); mvy = -int'(launch_vy); mstate = 1;
            end
        end else if (mstate == 1) begin
            if (t) begin
                land = 1'b0;
                nx = mx + mvx;
                ny = my + mvy;
                nvy = (mvy >= 31) ? 31 : mvy + 1;
                if (nx >= 608) begin mx = 608; land = 1'b1; end
                else mx = nx;
                if (ny < 0) begin my = 0; nvy = 0; end
                else if (ny >= 448) begin
                    my = 448;
`ifdef BALL_BOUNCE_EN
                    if (mvy < 2) land = 1'b1;
                    else nvy = -(mvy / 2);
`else
                    land = 1'b1;
`endif
                end else my = ny;
                mvy = nvy;
                if (land) begin mstate = 2; mcnt = 0; msd = 1'b1; end
            end
        end else begin
            if (t) begin
                if (mcnt == 59) begin mstate = 0; mcnt = 0; mx = 100; my = 400; end
                else mcnt++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [21:0] obs, input logic [21:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed x=%0d y=%0d fl=%0b sd=%0b expected x=%0d y=%0d fl=%0b sd=%0b",
                   tag, obs[21:12], obs[11:2], obs[1], obs[0], exp[21:12], exp[11:2], exp[1], exp[0]);
        end
    endtask

    task automatic check_now(input string tag, input int x, input int y, input bit fl, input bit sd);
        check(tag, {ball_x, ball_y, in_flight, shot_done}, {10'(x), 10'(y), fl, sd});
    endtask

    task automatic check_shots(input string tag, input int exp);
        n_assert++;
        assert (shots === exp) else begin
            n_fail++;
            $error("FAIL %s: shot_done pulses observed %0d expected %0d", tag, shots, exp);
        end
    endtask

    // One clock cycle: drive inputs, push model expectation, compare after edge.
    task automatic cyc(input bit l, input bit t, input bit r);
        logic [21:0] e;
        @(negedge clk);
        launch = l; frame_tick = t; reset = r;
        model_step(l, t, r);
        sb_q.push_back({10'(mx), 10'(my), (mstate == 1), msd});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({phase, "/sb"}, {ball_x, ball_y, in_flight, shot_done}, e);
        if (shot_done === 1'b1) shots++;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // reset and idle
        phase = "reset";
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        check_now("reset_state", 100, 400, 1'b0, 1'b0);
        phase = "idle";
        tick_n(5);
        check_now("idle_5_ticks", 100, 400, 1'b0, 1'b0);

        // launch vx=4 vy=10
        phase = "shot_a";
        launch_vx = 4'd4; launch_vy = 5'd10;
        cyc(1'b1, 1'b0, 1'b0);
        check_now("after_launch", 100, 400, 1'b1, 1'b0);
        tick_n(1);
        check_now("first_tick", 104, 390, 1'b1, 1'b0);
        tick_n(9);
        check_now("apex_10_ticks", 140, 345, 1'b1, 1'b0);
        shots = 0;
        tick_n(15);
`ifndef BALL_BOUNCE_EN
        check_now("floor_landed", 200, 448, 1'b0, 1'b0);
        check_shots("floor_shot_once", 1);
`endif
        tick_n(30);
        phase = "reset_hold";
        cyc(1'b1, 1'b1, 1'b1);
        check_now("reset_mid_hold", 100, 400, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check_now("launch_with_reset_ignored", 100, 400, 1'b0, 1'b0);

        // launch vx=15 vy=31: wall hit, with a launch attempt during flight
        phase = "shot_b";
        launch_vx = 4'd15; launch_vy = 5'd31;
        cyc(1'b1, 1'b0, 1'b0);
        shots = 0;
        tick_n(4);
        launch_vx = 4'd1; launch_vy = 5'd2;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check_now("launch_in_flight_ignored", 100 + 75, 400 - 31 - 30 - 29 - 28 - 27, 1'b1, 1'b0);
        tick_n(29);
        check_now("wall_clamp", 608, 120, 1'b0, 1'b0);
        check_shots("wall_shot_once", 1);
        tick_n(59);
        check_now("hold_59", 608, 120, 1'b0, 1'b0);
        tick_n(1);
        check_now("return_after_60", 100, 400, 1'b0, 1'b0);
        check_shots("hold_no_extra_shot", 1);

        // launch together with frame_tick, vx=0 vy=0: drop onto the floor
        phase = "shot_c";
        launch_vx = 4'd0; launch_vy = 5'd0;
        shots = 0;
        cyc(1'b1, 1'b1, 1'b0);
        check_now("launch_tick_no_motion", 100, 400, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        tick_n(4);
        check_now("drop_4_ticks", 100, 406, 1'b1, 1'b0);
`ifndef BALL_BOUNCE_EN
        tick_n(6);
        check_now("drop_10_ticks", 100, 445, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        check_now("drop_floor_clamp", 100, 448, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check_shots("drop_shot_once", 1);
        tick_n(3);
`else
        tick_n(40);
`endif
        phase = "reset_c";
        cyc(1'b1, 1'b1, 1'b1);
        check_now("reset_after_drop", 100, 400, 1'b0, 1'b0);

        // reset in mid flight
        phase = "shot_d";
        launch_vx = 4'd3; launch_vy = 5'd5;
        cyc(1'b1, 1'b0, 1'b0);
        tick_n(3);
        check_now("flight_d_3_ticks", 109, 388, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        check_now("reset_mid_flight", 100, 400, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        check_now("idle_after_flight_reset", 100, 400, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_motion.md
BALL_MOTION -- requirements
Module: ball_motion

Interface
REQ-001 SHALL have parameter START_X, default 100: ball x at rest, in pixels.
REQ-002 SHALL have parameter START_Y, default 400: ball y at rest, in pixels.
REQ-003 SHALL have parameter BALL_SIZE, default 16: ball square edge, in pixels.
REQ-004 SHALL have parameter FLOOR_Y, default 464: floor line; ball y limit is FLOOR_Y-BALL_SIZE.
REQ-005 SHALL have parameter RIGHT_X, default 624: right wall; ball x limit is RIGHT_X-BALL_SIZE.
REQ-006 SHALL have parameter HOLD_FRAMES, default 60: frames spent in LANDED.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-009 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame from the sync stage.
REQ-010 SHALL have port launch, input, 1 bit: one-cycle shot request.
REQ-011 SHALL have port launch_vx, input, 4 bits: unsigned horizontal speed, in px/frame.
REQ-012 SHALL have port launch_vy, input, 5 bits: unsigned upward speed, in px/frame.
REQ-013 SHALL have port ball_x, output, 10 bits: registered ball x, fed directly to pixel_Gen ball_x.
REQ-014 SHALL have port ball_y, output, 10 bits: registered ball y, fed directly to pixel_Gen ball_y.
REQ-015 SHALL have port in_flight, output, 1 bit: high while state is FLIGHT.
REQ-016 SHALL have port shot_done, output, 1 bit: one-cycle pulse when the ball enters LANDED.

Function
REQ-017 SHALL implement three states (IDLE, FLIGHT, LANDED) and hold an internal signed 8-bit vy (positive = down) and an unsigned 4-bit vx.
REQ-018 In IDLE, the block SHALL hold ball_x=START_X and ball_y=START_Y; launch=1 SHALL, at the next edge, load vx=launch_vx and vy=-launch_vy and enter FLIGHT.
REQ-019 When launch and frame_tick are both high in IDLE, launch SHALL take priority and no motion SHALL occur in that frame.
REQ-020 In FLIGHT, on each frame_tick the block SHALL update x+=vx, y+=vy (using the old vy), then vy+=1, with vy saturating at +31; outputs change 1 cycle after frame_tick.
REQ-021 Position arithmetic SHALL use 11-bit signed intermediates; if y+vy<0, y SHALL clamp to 0 and vy SHALL be set to 0.
REQ-022 If x+vx >= RIGHT_X-BALL_SIZE, x SHALL clamp to that value and the block SHALL enter LANDED.
REQ-023 If y+vy >= FLOOR_Y-BALL_SIZE, y SHALL clamp to that value and the block SHALL enter LANDED (see REQ-030); if both wall and floor are hit in one tick, both clamps SHALL apply.
REQ-024 shot_done SHALL pulse high for exactly the one cycle following the transition into LANDED.
REQ-025 In LANDED, the position SHALL be held and a frame counter SHALL count frame_tick pulses; after HOLD_FRAMES ticks the block SHALL enter IDLE with the position reset to the start position.
REQ-026 launch SHALL be ignored in FLIGHT and LANDED.

Reset
REQ-027 On reset=1 at a clock edge, the state SHALL become IDLE, ball_x=START_X, ball_y=START_Y, vx=0, vy=0, in_flight=0, shot_done=0, and the frame counter SHALL be 0.
REQ-028 Reset SHALL override launch and frame_tick in the same cycle, including mid-flight and mid-hold.

Configuration
REQ-029 SHALL support the macro BALL_BOUNCE_EN.
REQ-030 With BALL_BOUNCE_EN defined, a floor hit SHALL clamp y and set vy=-(vy>>>1), staying in FLIGHT; LANDED SHALL be entered only on a floor hit with vy<2 or on a wall hit.
REQ-031 Without BALL_BOUNCE_EN, any floor hit SHALL enter LANDED immediately.

Verification
REQ-032 Reset, then idle for 5 frame_ticks -> ball at (100,400), in_flight=0, shot_done=0.
REQ-033 Launch with vx=4 and vy=10, then 1 frame_tick -> (104,390) with vy=-9; after 10 ticks -> (140,345) with vy=0.
REQ-034 Launch with vx=15 and vy=31 -> x clamps to 608 with y unchanged by the clamp, LANDED is entered, shot_done pulses once, and the ball returns to (100,400) after 60 ticks.
REQ-035 Launch with vx=0 and vy=0, without BALL_BOUNCE_EN -> y increments 400,400,401,403,406,... and clamps at 448 with shot_done; with BALL_BOUNCE_EN -> the ball rebounds with vy halved until vy<2.
REQ-036 Assert reset mid-FLIGHT and mid-LANDED -> all outputs reach their reset values at the next edge; a launch asserted in the same cycle as reset is ignored.
REQ-037 Assert launch during FLIGHT, and launch together with frame_tick in IDLE -> the first is ignored; for the second, the position is unchanged in that frame.
